// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with parametrised memory wait states, addi, jr, halt/resume.
// Optional macro ILLEGAL_TRAP_EN: undefined instructions trap into ILLEGAL
// (sticky illegal_op) instead of behaving as nop.
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read instruction, PC+4 in ALU, lasts MEM_WAIT+1 cycles
// DECODE   | PC <= PC+4, latch A/B, dispatch on opcode/funct
// EXEC_R   | R-type ALU operation
// WB_R     | write R-type result to rd
// JR       | PC <= A
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read, lasts MEM_WAIT+1 cycles
// MEM_WB   | write loaded data to rt
// MEM_WR   | data write, lasts MEM_WAIT+1 cycles
// EXEC_I   | addi ALU operation
// WB_I     | write addi result to rt
// LUI      | write imm<<16 to rt
// JUMP     | PC <= jump target
// BR_ADDR  | branch target into AluOut
// BR_CMP   | compare A-B, conditionally take branch
// HALT     | idle until resume
// ILLEGAL  | trapped on undefined instruction, left only by reset
module multicycle_control_unit #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero_flag,
    input  logic             resume,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemReadWrite,
    output logic             IRWrite,
    output logic             AluSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             AWrite,
    output logic             BWrite,
    output logic             AluOutWrite,
    output logic             MDRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       MemtoReg,
    output logic [2:0]       ALUOp,
    output logic [4:0]       State_out,
    output logic [CNT_W-1:0] wait_count,
    output logic             halted,
    output logic             illegal_op
);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_EXEC_R   = 5'd2,
        S_WB_R     = 5'd3,
        S_JR       = 5'd4,
        S_MEM_ADDR = 5'd5,
        S_MEM_RD   = 5'd6,
        S_MEM_WB   = 5'd7,
        S_MEM_WR   = 5'd8,
        S_EXEC_I   = 5'd9,
        S_WB_I     = 5'd10,
        S_LUI      = 5'd11,
        S_JUMP     = 5'd12,
        S_BR_ADDR  = 5'd13,
        S_BR_CMP   = 5'd14,
        S_HALT     = 5'd15,
        S_ILLEGAL  = 5'd16
    } state_t;

    localparam logic [2:0] ALU_LOAD = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd6;

    localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(MEM_WAIT);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t UNDEF_TARGET = S_ILLEGAL;
`else
    localparam state_t UNDEF_TARGET = S_FETCH;
`endif

    state_t           state, state_nxt, dec_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             wait_done;
    logic             counted;

    assign wait_done  = (count == WAIT_TC);
    assign counted    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign State_out  = state;
    assign wait_count = count;

    // State register and wait counter; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, set on the edge that enters ILLEGAL.
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_nxt == S_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // Instruction dispatch target out of DECODE.
    always_comb begin
        dec_nxt = UNDEF_TARGET;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h26: dec_nxt = S_EXEC_R;
                    6'h08:                      dec_nxt = S_JR;
                    6'h00:                      dec_nxt = S_FETCH;
                    6'h0D:                      dec_nxt = S_HALT;
                    default:                    dec_nxt = UNDEF_TARGET;
                endcase
            end
            6'h02:        dec_nxt = S_JUMP;
            6'h04, 6'h05: dec_nxt = S_BR_ADDR;
            6'h08:        dec_nxt = S_EXEC_I;
            6'h0F:        dec_nxt = S_LUI;
            6'h23, 6'h2B: dec_nxt = S_MEM_ADDR;
            default:      dec_nxt = UNDEF_TARGET;
        endcase
    end

    // Next state, wait counter and datapath controls decoded from current state.
    always_comb begin
        state_nxt    = state;
        count_nxt    = (counted && !wait_done) ? count + CNT_W'(1) : '0;
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        MemReadWrite = 1'b0;
        IRWrite      = 1'b0;
        AluSrcA      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        AWrite       = 1'b0;
        BWrite       = 1'b0;
        AluOutWrite  = 1'b0;
        MDRWrite     = 1'b0;
        PCSource     = 2'd0;
        AluSrcB      = 2'd0;
        MemtoReg     = 2'd0;
        ALUOp        = ALU_LOAD;
        halted       = 1'b0;
        case (state)
            S_FETCH: begin
                AluSrcB  = 2'd1;
                ALUOp    = ALU_ADD;
                MDRWrite = 1'b1;
                IRWrite  = wait_done;
                if (wait_done) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                PCWrite   = 1'b1;
                AWrite    = 1'b1;
                BWrite    = 1'b1;
                state_nxt = dec_nxt;
            end
            S_EXEC_R: begin
                AluSrcA     = 1'b1;
                AluOutWrite = 1'b1;
                case (funct)
                    6'h22:   ALUOp = ALU_SUB;
                    6'h24:   ALUOp = ALU_AND;
                    6'h26:   ALUOp = ALU_XOR;
                    default: ALUOp = ALU_ADD;
                endcase
                state_nxt = S_WB_R;
            end
            S_WB_R: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JR: begin
                PCWrite   = 1'b1;
                PCSource  = 2'd3;
                state_nxt = S_FETCH;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                AluSrcA     = 1'b1;
                AluSrcB     = 2'd2;
                ALUOp       = ALU_ADD;
                AluOutWrite = 1'b1;
                if (state == S_EXEC_I)    state_nxt = S_WB_I;
                else if (opcode == 6'h23) state_nxt = S_MEM_RD;
                else                      state_nxt = S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD     = 1'b1;
                MDRWrite = wait_done;
                if (wait_done) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 2'd1;
                state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                IorD         = 1'b1;
                MemReadWrite = 1'b1;
                if (wait_done) state_nxt = S_FETCH;
            end
            S_WB_I: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_LUI: begin
                RegWrite  = 1'b1;
                MemtoReg  = 2'd2;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'd2;
                state_nxt = S_FETCH;
            end
            S_BR_ADDR: begin
                AluSrcB     = 2'd3;
                ALUOp       = ALU_ADD;
                AluOutWrite = 1'b1;
                state_nxt   = S_BR_CMP;
            end
            S_BR_CMP: begin
                AluSrcA   = 1'b1;
                ALUOp     = ALU_SUB;
                PCSource  = 2'd1;
                PCWrite   = (opcode == 6'h04) ? Zero_flag : !Zero_flag;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) state_nxt = S_FETCH;
            end
            S_ILLEGAL: begin
                state_nxt = S_ILLEGAL;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a driver expands each
// instruction into its expected per-cycle control vectors and queues them;
// a negedge monitor pops and compares one vector per cycle.
module tb_multicycle_control_unit;

    localparam int MW = 2;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          Zero_flag = 1'b0;
    logic          resume = 1'b0;
    logic          PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, RegDst;
    logic          AWrite, BWrite, AluOutWrite, MDRWrite;
    logic [1:0]    PCSource, AluSrcB, MemtoReg;
    logic [2:0]    ALUOp;
    logic [4:0]    State_out;
    logic [CW-1:0] wait_count;
    logic          halted, illegal_op;

    multicycle_control_unit #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .Zero_flag(Zero_flag), .resume(resume),
        .PCWrite(PCWrite), .IorD(IorD), .MemReadWrite(MemReadWrite), .IRWrite(IRWrite),
        .AluSrcA(AluSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .AWrite(AWrite),
        .BWrite(BWrite), .AluOutWrite(AluOutWrite), .MDRWrite(MDRWrite),
        .PCSource(PCSource), .AluSrcB(AluSrcB), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
        .State_out(State_out), .wait_count(wait_count), .halted(halted),
        .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]    st;
        logic [CW-1:0] wc;
        logic          pcw, iord, mrw, irw, asa, rw, rd, aw, bw, aow, mdrw;
        logic [1:0]    pcs, asb, mtr;
        logic [2:0]    alu;
        logic          hlt, ill;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    obs_t mon_e, mon_a;

    function automatic obs_t blank(int st, int wc);
        obs_t r;
        r = '0;
        r.st = 5'(st);
        r.wc = CW'(wc);
        return r;
    endfunction

    // Expand one instruction into expected cycles, drive it, optionally reset afterwards.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int hlen, input int abort);
        obs_t recs[$];
        bit   rs[$];
        obs_t r;
        int   cut;
        cut = abort;
        for (int c = 0; c <= MW; c++) begin
            r = blank(0, c); r.asb = 2'd1; r.alu = 3'd1; r.mdrw = 1'b1; r.irw = (c == MW);
            recs.push_back(r); rs.push_back(1'b0);
        end
        r = blank(1, 0); r.pcw = 1'b1; r.aw = 1'b1; r.bw = 1'b1;
        recs.push_back(r); rs.push_back(1'b0);
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h26}) begin
            r = blank(2, 0); r.asa = 1'b1; r.aow = 1'b1;
            r.alu = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd6;
            recs.push_back(r); rs.push_back(1'b0);
            r = blank(3, 0); r.rw = 1'b1; r.rd = 1'b1;
            recs.push_back(r); rs.push_back(1'b0);
        end else if (op == 6'h00 && fn == 6'h08) begin
            r = blank(4, 0); r.pcw = 1'b1; r.pcs = 2'd3;
            recs.push_back(r); rs.push_back(1'b0);
        end else if (op == 6'h00 && fn == 6'h00) begin
            // nop: straight back to fetch
        end else if (op == 6'h00 && fn == 6'h0D) begin
            for (int i = 0; i < hlen; i++) begin
                r = blank(15, 0); r.hlt = 1'b1;
                recs.push_back(r); rs.push_back(i == hlen - 1);
            end
        end else if (op == 6'h02) begin
            r = blank(12, 0); r.pcw = 1'b1; r.pcs = 2'd2;
            recs.push_back(r); rs.push_back(1'b0);
        end else if (op == 6'h04 || op == 6'h05) begin
            r = blank(13, 0); r.asb = 2'd3; r.alu = 3'd1; r.aow = 1'b1;
            recs.push_back(r); rs.push_back(1'b0);
            r = blank(14, 0); r.asa = 1'b1; r.alu = 3'd2; r.pcs = 2'd1;
            r.pcw = (op == 6'h04) ? z : !z;
            recs.push_back(r); rs.push_back(1'b0);
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            r = blank((op == 6'h08) ? 9 : 5, 0); r.asa = 1'b1; r.asb = 2'd2; r.alu = 3'd1; r.aow = 1'b1;
            recs.push_back(r); rs.push_back(1'b0);
            if (op == 6'h08) begin
                r = blank(10, 0); r.rw = 1'b1;
                recs.push_back(r); rs.push_back(1'b0);
            end else if (op == 6'h23) begin
                for (int c = 0; c <= MW; c++) begin
                    r = blank(6, c); r.iord = 1'b1; r.mdrw = (c == MW);
                    recs.push_back(r); rs.push_back(1'b0);
                end
                r = blank(7, 0); r.rw = 1'b1; r.mtr = 2'd1;
                recs.push_back(r); rs.push_back(1'b0);
            end else begin
                for (int c = 0; c <= MW; c++) begin
                    r = blank(8, c); r.iord = 1'b1; r.mrw = 1'b1;
                    recs.push_back(r); rs.push_back(1'b0);
                end
            end
        end else if (op == 6'h0F) begin
            r = blank(11, 0); r.rw = 1'b1; r.mtr = 2'd2;
            recs.push_back(r); rs.push_back(1'b0);
        end else begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < hlen; i++) begin
                r = blank(16, 0); r.ill = 1'b1;
                recs.push_back(r); rs.push_back(1'($urandom_range(0, 1)));
            end
            cut = recs.size();
`endif
        end
        if (cut > 0) begin
            while (recs.size() > cut) begin
                void'(recs.pop_back());
                void'(rs.pop_back());
            end
        end
        opcode = op; funct = fn; Zero_flag = z;
        foreach (recs[i]) exp_q.push_back(recs[i]);
        foreach (recs[i]) begin
            resume = rs[i];
            @(posedge clock); #1;
        end
        resume = 1'b0;
        if (cut > 0) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
        end
    endtask

    // Monitor: one expected vector per cycle while the scoreboard holds any.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '0;
            mon_a.st = State_out; mon_a.wc = wait_count;
            mon_a.pcw = PCWrite; mon_a.iord = IorD; mon_a.mrw = MemReadWrite; mon_a.irw = IRWrite;
            mon_a.asa = AluSrcA; mon_a.rw = RegWrite; mon_a.rd = RegDst; mon_a.aw = AWrite;
            mon_a.bw = BWrite; mon_a.aow = AluOutWrite; mon_a.mdrw = MDRWrite;
            mon_a.pcs = PCSource; mon_a.asb = AluSrcB; mon_a.mtr = MemtoReg; mon_a.alu = ALUOp;
            mon_a.hlt = halted; mon_a.ill = illegal_op;
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL ctrl_vec #%0d state=%0d: got %h expected %h (st,wc,pcw,iord,mrw,irw,asa,rw,rd,aw,bw,aow,mdrw,pcs,asb,mtr,alu,hlt,ill)",
                         vectors, mon_e.st, mon_a, mon_e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        int         k, len;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        issue(6'h00, 6'h20, 1'b0, 0, 0);   // add
        issue(6'h00, 6'h22, 1'b0, 0, 0);   // sub
        issue(6'h00, 6'h24, 1'b0, 0, 0);   // and
        issue(6'h00, 6'h26, 1'b0, 0, 0);   // xor
        issue(6'h23, 6'h11, 1'b0, 0, 0);   // lw
        issue(6'h2B, 6'h05, 1'b0, 0, 0);   // sw
        issue(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        issue(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
        issue(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
        issue(6'h05, 6'h00, 1'b0, 0, 0);   // bne taken
        issue(6'h00, 6'h0D, 1'b0, 6, 0);   // halt, 5 idle cycles then resume
        issue(6'h00, 6'h0D, 1'b0, 6, 8);   // halt, reset while halted
        issue(6'h00, 6'h08, 1'b0, 0, 0);   // jr
        issue(6'h02, 6'h3F, 1'b0, 0, 0);   // j
        issue(6'h08, 6'h00, 1'b0, 0, 0);   // addi
        issue(6'h0F, 6'h00, 1'b0, 0, 0);   // lui
        issue(6'h00, 6'h00, 1'b0, 0, 0);   // nop
        issue(6'h3F, 6'h00, 1'b0, 4, 0);   // undefined opcode
        issue(6'h00, 6'h01, 1'b0, 3, 0);   // undefined funct
        issue(6'h23, 6'h00, 1'b0, 0, MW + 4); // lw abandoned mid-read

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 14);
            fn = 6'($urandom);
            case (k)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h24; end
                3: begin op = 6'h00; fn = 6'h26; end
                4: begin op = 6'h00; fn = 6'h08; end
                5: begin op = 6'h00; fn = 6'h00; end
                6: begin op = 6'h00; fn = 6'h0D; end
                7: op = 6'h02;
                8: op = 6'h04;
                9: op = 6'h05;
                10: op = 6'h08;
                11: op = 6'h0F;
                12: op = 6'h23;
                13: op = 6'h2B;
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        op = 6'h00;
                        do fn = 6'($urandom);
                        while (fn inside {6'h00, 6'h08, 6'h0D, 6'h20, 6'h22, 6'h24, 6'h26});
                    end else begin
                        do op = 6'($urandom);
                        while (op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0F, 6'h23, 6'h2B});
                    end
                end
            endcase
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 0;
            issue(op, fn, 1'($urandom), $urandom_range(1, 4), len);
        end

        repeat (2) @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multicycle MIPS control FSM. Sequences fetch, decode, execute, memory and writeback, and drives datapath mux selects, register write enables and ALU operation.
- Memory wait states come from a counter sized by parameter, not from hard-coded wait states.
- Adds addi, jr, halt/resume and an optional illegal-instruction trap.

Parameters:
MEM_WAIT, 2, extra memory cycles per access (0..2**CNT_W-1); each access lasts MEM_WAIT+1 cycles
CNT_W, 4, width of wait counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
Zero_flag  in  1  ALU zero result
resume  in  1  leave HALT; sampled only in HALT
PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, RegDst, AWrite, BWrite, AluOutWrite, MDRWrite  out  1 each  datapath controls
PCSource  out  2  0=ALU, 1=AluOut, 2=jump target, 3=A (jr)
AluSrcB  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=imm<<2
MemtoReg  out  2  0=AluOut, 1=MDR, 2=imm<<16
ALUOp  out  3  LOAD=0 ADD=1 SUB=2 AND=3 INC=4 NEG=5 XOR=6 COMP=7
State_out  out  5  current state encoding
wait_count  out  CNT_W  current memory wait counter
halted  out  1  1 while in HALT
illegal_op  out  1  sticky illegal-instruction flag

Behaviour:
- Reset is synchronous, active-high, and wins over all other inputs. Next edge: state=FETCH, wait_count=0, illegal_op=0. Any access or write in progress is abandoned.
- Outputs are a combinational decode of state, count and inputs. Default for every output is 0, with ALUOp=LOAD.
- Post-reset outputs are the FETCH values: AluSrcB=1, ALUOp=ADD, IRWrite=(MEM_WAIT==0), all others 0.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, JR=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, EXEC_I=9, WB_I=10, LUI=11, JUMP=12, BR_ADDR=13, BR_CMP=14, HALT=15, ILLEGAL=16.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while count<MEM_WAIT.
  - The state exits on the cycle where count==MEM_WAIT, so each of these states lasts exactly MEM_WAIT+1 cycles.
  - Counter holds 0 in all other states.
- FETCH: IorD=0, MemReadWrite=0, AluSrcA=0, AluSrcB=1, ALUOp=ADD, MDRWrite=1. IRWrite=1 only when count==MEM_WAIT, then -> DECODE.
- DECODE (1 cycle): PCWrite=1, PCSource=0 (PC+4), AWrite=BWrite=1. Next state by opcode/funct:
  - opcode 0x00: funct 0x20/0x22/0x24/0x26 -> EXEC_R; 0x08 -> JR; 0x00 nop -> FETCH; 0x0D -> HALT.
  - 0x02 -> JUMP; 0x04/0x05 -> BR_ADDR; 0x08 -> EXEC_I; 0x0F -> LUI; 0x23/0x2B -> MEM_ADDR.
  - Anything else -> undefined handling (see Optional Feature).
- EXEC_R: AluSrcA=1, AluSrcB=0, AluOutWrite=1. ALUOp: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR. -> WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- JR: PCWrite=1, PCSource=3 -> FETCH.
- EXEC_I and MEM_ADDR: AluSrcA=1, AluSrcB=2, ALUOp=ADD, AluOutWrite=1.
  - EXEC_I -> WB_I (RegWrite=1, RegDst=0, MemtoReg=0) -> FETCH.
  - MEM_ADDR -> MEM_RD if opcode 0x23, else MEM_WR.
- MEM_RD: IorD=1, MemReadWrite=0. MDRWrite=1 only when count==MEM_WAIT, then -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEM_WR: IorD=1, MemReadWrite=1, held for all MEM_WAIT+1 cycles -> FETCH.
- LUI: RegWrite=1, RegDst=0, MemtoReg=2 -> FETCH.
- JUMP: PCWrite=1, PCSource=2 -> FETCH.
- BR_ADDR: AluSrcA=0, AluSrcB=3, ALUOp=ADD, AluOutWrite=1 -> BR_CMP.
- BR_CMP: AluSrcA=1, AluSrcB=0, ALUOp=SUB, PCSource=1, PCWrite = (opcode==0x04) ? Zero_flag : !Zero_flag -> FETCH.
- HALT: all enables 0, halted=1. resume=1 -> FETCH next edge; otherwise stay. reset while halted -> FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Undefined opcode/funct in DECODE -> ILLEGAL; illegal_op set on entry.
  - ILLEGAL: all enables 0, stays until reset. resume is ignored.
  - illegal_op is sticky until reset.
- Undefined: undefined instructions behave as nop (DECODE -> FETCH); ILLEGAL is unreachable and illegal_op is tied to 0.

Test Plan:
- Reset with MEM_WAIT=2 -> State_out=0, wait_count=0, IRWrite=1 on 3rd FETCH cycle only, DECODE on 4th cycle with PCWrite=1.
- add (opcode 0, funct 0x20) -> EXEC_R with ALUOp=1, AluOutWrite=1; then WB_R with RegWrite=1, RegDst=1; FETCH; 6 cycles total at MEM_WAIT=2.
- lw (0x23) with MEM_WAIT=0 -> MEM_ADDR, MEM_RD (1 cycle, MDRWrite=1), MEM_WB (MemtoReg=1); sw (0x2B) -> MemReadWrite=1 for exactly 1 cycle.
- beq (0x04) with Zero_flag=1 -> PCWrite=1, PCSource=1 in BR_CMP; bne (0x05) with Zero_flag=1 -> PCWrite=0.
- break (funct 0x0D) -> halted=1 for 5 cycles with resume=0; resume=1 -> FETCH next edge, halted=0.
- opcode 0x3F with ILLEGAL_TRAP_EN -> State_out=16, illegal_op=1 held through resume=1 and cleared only by reset; without the macro -> returns to FETCH, illegal_op=0.
